// File: rtl/fetch_stage.sv
// Instruction fetch: streams 32-bit words from PC_RESET (or a redirect target) to decode with their PCs.
// Latency: first insn_valid 2 cycles after start/redirect is sampled; one word per cycle when decode is ready.
// Backpressure: 2-entry buffer; a read issues only when a slot is guaranteed, so decode stalls never drop words.
module fetch_stage #(
    parameter logic [31:0] PC_RESET   = 32'h8002_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        insn_ready,
    output logic        insn_valid,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_write,
    output logic [1:0]  mem_access_size,
    input  logic [31:0] mem_data_out,
    output logic        running
);
    localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] mem_addr_q;
    logic [31:0] tag;
    logic        inflight;
    logic [1:0]  count;
    entry_t      head;
    entry_t      tail;

    logic        pop;
    logic        issue;
    logic [2:0]  credit;
    entry_t      fill;

    // Occupancy after this cycle's pop, plus the read still in flight.
    assign pop    = (count != 2'd0) && insn_ready;
    assign credit = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue  = (state == RUN) && !redirect_valid && (credit < DEPTH);
    assign fill   = '{word: mem_data_out, pc: tag};

    assign mem_address     = issue ? fetch_pc : mem_addr_q;
    assign mem_data_in     = 32'd0;
    assign mem_write       = 1'b0;
    assign mem_access_size = 2'b10;

    // Head register doubles as the output, so insn/insn_pc hold when the buffer drains.
    assign insn_valid = (count != 2'd0);
    assign insn       = head.word;
    assign insn_pc    = head.pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            running    <= 1'b0;
            fetch_pc   <= PC_RESET;
            mem_addr_q <= PC_RESET;
            tag        <= '0;
            inflight   <= 1'b0;
            count      <= 2'd0;
            head       <= '0;
            tail       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        running  <= 1'b1;
                        fetch_pc <= PC_RESET;
                    end
                end
                RUN: begin
                    if (redirect_valid) begin
                        // Any handshake this cycle still completes; everything else is dropped.
                        fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
                        inflight <= 1'b0;
                        count    <= 2'd0;
                    end else begin
                        inflight <= issue;
                        if (issue) begin
                            mem_addr_q <= fetch_pc;
                            tag        <= fetch_pc;
                            fetch_pc   <= fetch_pc + 32'd4;
                        end
                        case ({inflight, pop})
                            2'b10: begin
                                if (count == 2'd0) head <= fill;
                                else               tail <= fill;
                                count <= count + 2'd1;
                            end
                            2'b01: begin
                                if (count == 2'd2) head <= tail;
                                count <= count - 2'd1;
                            end
                            2'b11: begin
                                if (count == 2'd2) begin
                                    head <= tail;
                                    tail <= fill;
                                end else begin
                                    head <= fill;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: scoreboard of expected {pc, word} pairs, consumed on each decode handshake.
module tb_fetch_stage;
    localparam logic [31:0] PC0 = 32'h8002_0000;

    logic        clk;
    logic        rst;
    logic        start;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        insn_ready;
    logic        insn_valid;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_write;
    logic [1:0]  mem_access_size;
    logic [31:0] mem_data_out;
    logic        running;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t sb_q[$];
    int   tests_run = 0;
    int   failed    = 0;
    int   hs        = 0;

    fetch_stage #(.PC_RESET(PC0), .FIFO_DEPTH(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .insn_ready      (insn_ready),
        .insn_valid      (insn_valid),
        .insn            (insn),
        .insn_pc         (insn_pc),
        .mem_address     (mem_address),
        .mem_data_in     (mem_data_in),
        .mem_write       (mem_write),
        .mem_access_size (mem_access_size),
        .mem_data_out    (mem_data_out),
        .running         (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h8002_0000: return 32'h1111_1111;
            32'h8002_0004: return 32'h2222_2222;
            32'h8002_0008: return 32'h3333_3333;
            default:       return a ^ 32'h5EED_C0DE;
        endcase
    endfunction

    // Synchronous read memory: address sampled at the edge, data valid the following cycle.
    always @(posedge clk) mem_data_out <= mem_word(mem_address);

    task automatic push_seq(input logic [31:0] pc0, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.pc   = pc0 + 32'(4 * k);
            e.word = mem_word(e.pc);
            sb_q.push_back(e);
        end
    endtask

    task automatic scoreboard();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && insn_valid && insn_ready) begin
                tests_run++;
                hs++;
                if (sb_q.size() == 0) begin
                    failed++;
                    $display("FAIL sb_extra: got pc=%h insn=%h, expected no word", insn_pc, insn);
                end else begin
                    e = sb_q.pop_front();
                    if (insn_pc !== e.pc || insn !== e.word) begin
                        failed++;
                        $display("FAIL sb_word: got pc=%h insn=%h, expected pc=%h insn=%h",
                                 insn_pc, insn, e.pc, e.word);
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; insn_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic wait_hs(input int target);
        for (int i = 0; i < 40 && hs < target; i++) @(posedge clk);
        #1 insn_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; insn_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (insn_valid !== 1'b0 || running !== 1'b0) begin
            failed++;
            $display("FAIL reset_ctrl: valid=%b running=%b, expected 0 0", insn_valid, running);
        end
        tests_run++;
        if (mem_address !== PC0) begin
            failed++;
            $display("FAIL reset_addr: got %h, expected %h", mem_address, PC0);
        end
        tests_run++;
        if (insn !== 32'd0 || insn_pc !== 32'd0) begin
            failed++;
            $display("FAIL reset_insn: insn=%h pc=%h, expected 0 0", insn, insn_pc);
        end
        tests_run++;
        if (mem_write !== 1'b0 || mem_access_size !== 2'b10 || mem_data_in !== 32'd0) begin
            failed++;
            $display("FAIL reset_memctl: write=%b size=%b din=%h, expected 0 10 0",
                     mem_write, mem_access_size, mem_data_in);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_stream();
        int h0;
        insn_ready = 1'b1; start = 1'b1;
        push_seq(PC0, 3);
        h0 = hs;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        tests_run++;
        if (insn_valid !== 1'b0 || running !== 1'b1) begin
            failed++;
            $display("FAIL stream_lat0: valid=%b running=%b, expected 0 1", insn_valid, running);
        end
        @(negedge clk);
        tests_run++;
        if (insn_valid !== 1'b0) begin
            failed++;
            $display("FAIL stream_lat1: valid=%b, expected 0", insn_valid);
        end
        @(negedge clk);
        tests_run++;
        if (insn_valid !== 1'b1 || insn_pc !== PC0) begin
            failed++;
            $display("FAIL stream_lat2: valid=%b pc=%h, expected 1 %h", insn_valid, insn_pc, PC0);
        end
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 insn_ready = 1'b0;
        tests_run++;
        if (hs - h0 !== 3 || sb_q.size() != 0) begin
            failed++;
            $display("FAIL stream_count: %0d words, %0d left, expected 3 0", hs - h0, sb_q.size());
        end
    endtask

    task automatic test_stall();
        int h0;
        do_reset();
        start = 1'b1;
        push_seq(PC0, 3);
        h0 = hs;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests_run++;
            if (insn_valid !== 1'b1 || insn !== 32'h1111_1111 || insn_pc !== PC0 || mem_address !== PC0 + 32'd4) begin
                failed++;
                $display("FAIL stall_hold: valid=%b insn=%h pc=%h addr=%h, expected 1 11111111 %h %h",
                         insn_valid, insn, insn_pc, mem_address, PC0, PC0 + 32'd4);
            end
        end
        @(posedge clk);
        #1 insn_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (insn_valid !== 1'b1) begin
                failed++;
                $display("FAIL stall_gap: valid=%b at release cycle %0d, expected 1", insn_valid, i);
            end
        end
        @(posedge clk);
        #1 insn_ready = 1'b0;
        tests_run++;
        if (hs - h0 !== 3 || sb_q.size() != 0) begin
            failed++;
            $display("FAIL stall_count: %0d words, %0d left, expected 3 0", hs - h0, sb_q.size());
        end
    endtask

    task automatic test_redirect_full();
        int h0;
        do_reset();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if (insn_valid !== 1'b1 || mem_address !== PC0 + 32'd4) begin
            failed++;
            $display("FAIL redir_full_pre: valid=%b addr=%h, expected 1 %h", insn_valid, mem_address, PC0 + 32'd4);
        end
        @(posedge clk);
        #1 redirect_valid = 1'b1; redirect_pc = 32'h8002_0042;
        @(posedge clk);
        #1 redirect_valid = 1'b0; insn_ready = 1'b1;
        push_seq(32'h8002_0040, 3);
        h0 = hs;
        @(negedge clk);
        tests_run++;
        if (insn_valid !== 1'b0) begin
            failed++;
            $display("FAIL redir_full_flush: valid=%b, expected 0", insn_valid);
        end
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (insn_valid !== 1'b1 || insn_pc !== 32'h8002_0040) begin
            failed++;
            $display("FAIL redir_full_lat: valid=%b pc=%h, expected 1 80020040", insn_valid, insn_pc);
        end
        @(posedge clk);
        #1;
        wait_hs(h0 + 3);
        tests_run++;
        if (hs - h0 !== 3 || sb_q.size() != 0) begin
            failed++;
            $display("FAIL redir_full_count: %0d words, %0d left, expected 3 0", hs - h0, sb_q.size());
        end
    endtask

    task automatic test_redirect_handshake();
        int h0;
        do_reset();
        insn_ready = 1'b1; start = 1'b1;
        push_seq(PC0, 2);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 redirect_valid = 1'b1; redirect_pc = 32'h8002_1000;
        @(negedge clk);
        tests_run++;
        if (insn_valid !== 1'b1 || insn_pc !== PC0 + 32'd4) begin
            failed++;
            $display("FAIL redir_hs_coincide: valid=%b pc=%h, expected 1 %h", insn_valid, insn_pc, PC0 + 32'd4);
        end
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        tests_run++;
        if (sb_q.size() != 0) begin
            failed++;
            $display("FAIL redir_hs_consumed: %0d words left, expected 0", sb_q.size());
        end
        sb_q.delete();
        push_seq(32'h8002_1000, 3);
        h0 = hs;
        @(negedge clk);
        tests_run++;
        if (insn_valid !== 1'b0 || insn_pc !== PC0 + 32'd4) begin
            failed++;
            $display("FAIL redir_hs_hold: valid=%b pc=%h, expected 0 %h", insn_valid, insn_pc, PC0 + 32'd4);
        end
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (insn_valid !== 1'b1 || insn_pc !== 32'h8002_1000) begin
            failed++;
            $display("FAIL redir_hs_target: valid=%b pc=%h, expected 1 80021000", insn_valid, insn_pc);
        end
        @(posedge clk);
        #1;
        wait_hs(h0 + 3);
        tests_run++;
        if (hs - h0 !== 3 || sb_q.size() != 0) begin
            failed++;
            $display("FAIL redir_hs_count: %0d words, %0d left, expected 3 0", hs - h0, sb_q.size());
        end
    endtask

    task automatic test_wrap();
        int h0;
        do_reset();
        insn_ready = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        push_seq(32'hFFFF_FFF8, 3);
        h0 = hs;
        wait_hs(h0 + 3);
        tests_run++;
        if (hs - h0 !== 3 || sb_q.size() != 0) begin
            failed++;
            $display("FAIL wrap_count: %0d words, %0d left, expected 3 0", hs - h0, sb_q.size());
        end
    endtask

    task automatic test_idle();
        int h0;
        do_reset();
        insn_ready = 1'b1; start = 1'b1;
        push_seq(PC0, 20);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
        @(posedge clk);
        #1 rst = 1'b0; redirect_valid = 1'b0;
        sb_q.delete();
        @(negedge clk);
        tests_run++;
        if (insn_valid !== 1'b0 || running !== 1'b0 || mem_address !== PC0) begin
            failed++;
            $display("FAIL midrun_reset: valid=%b running=%b addr=%h, expected 0 0 %h",
                     insn_valid, running, mem_address, PC0);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 redirect_valid = (i == 5);
            @(negedge clk);
            tests_run++;
            if (insn_valid !== 1'b0 || running !== 1'b0 || mem_address !== PC0) begin
                failed++;
                $display("FAIL idle_gate: cycle %0d valid=%b running=%b addr=%h, expected 0 0 %h",
                         i, insn_valid, running, mem_address, PC0);
            end
        end
        @(posedge clk);
        #1 start = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
        push_seq(PC0, 3);
        h0 = hs;
        @(posedge clk);
        #1 start = 1'b0; redirect_valid = 1'b0;
        wait_hs(h0 + 3);
        tests_run++;
        if (hs - h0 !== 3 || sb_q.size() != 0) begin
            failed++;
            $display("FAIL start_wins: %0d words, %0d left, expected 3 0", hs - h0, sb_q.size());
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; insn_ready = 1'b0;
        fork
            scoreboard();
        join_none
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_redirect_handshake();
        test_wrap();
        test_idle();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end
endmodule
